// File: rtl/bfm_ahb_arb2.sv
// bfm_ahb_arb2: two-master AHB-Lite arbiter/mux in front of a single slave BFM.
// The address phase follows the address owner (own), write data and responses
// follow the data-phase owner (down). Ownership only moves on an owner-IDLE,
// unlocked boundary, which costs the waiting master one dead cycle.
// Optional statistics counters: define BFM_AHB_ARB2_STATS_EN.
module bfm_ahb_arb2 #(
  parameter int DEFAULT_OWNER = 0,
  parameter int TPD           = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  M0_HTRANS,
  input  logic [31:0] M0_HADDR,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M1_HADDR,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic [31:0] S_HADDR,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADYIN,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP
`ifdef BFM_AHB_ARB2_STATS_EN
  ,
  output logic [15:0] M0_WAITCNT,
  output logic [15:0] M1_WAITCNT,
  output logic [15:0] SWITCHCNT
`endif
);

  // TPD is a simulation timing annotation of the bridge BFM; this RTL is
  // zero-delay, so the parameter is only range-checked at elaboration.
  if (DEFAULT_OWNER < 0 || DEFAULT_OWNER > 1 || TPD < 0) begin : g_bad_param
    $error("bfm_ahb_arb2: DEFAULT_OWNER must be 0/1 and TPD non-negative");
  end

  localparam logic OWN_RST = (DEFAULT_OWNER == 1);

  logic own_q, own_d;
  logic dv_q, dv_d;
  logic down_q, down_d;

  logic req0, req1, req_own, req_oth, lock_own;

  assign req0     = M0_HTRANS[1];
  assign req1     = M1_HTRANS[1];
  assign req_own  = own_q ? req1 : req0;
  assign req_oth  = own_q ? req0 : req1;
  assign lock_own = own_q ? M1_HMASTLOCK : M0_HMASTLOCK;

  // State register: async reset drops any in-flight data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      own_q  <= OWN_RST;
      dv_q   <= 1'b0;
      down_q <= OWN_RST;
    end else begin
      own_q  <= own_d;
      dv_q   <= dv_d;
      down_q <= down_d;
    end
  end

  // Next state: advance only on a ready boundary; hand over only when the
  // owner is neither requesting nor locked (so it has no pending address).
  always_comb begin
    own_d  = own_q;
    dv_d   = dv_q;
    down_d = down_q;
    if (S_HREADYOUT) begin
      dv_d   = req_own;
      down_d = own_q;
      if (!req_own && !lock_own && req_oth) own_d = ~own_q;
    end
  end

  // Outputs: address mux by own, write data and responses by down, and a
  // requesting non-owner is stalled so it holds its address.
  always_comb begin
    S_HSEL      = 1'b1;
    S_HREADYIN  = S_HREADYOUT;
    S_HTRANS    = own_q ? M1_HTRANS    : M0_HTRANS;
    S_HADDR     = own_q ? M1_HADDR     : M0_HADDR;
    S_HWRITE    = own_q ? M1_HWRITE    : M0_HWRITE;
    S_HSIZE     = own_q ? M1_HSIZE     : M0_HSIZE;
    S_HBURST    = own_q ? M1_HBURST    : M0_HBURST;
    S_HPROT     = own_q ? M1_HPROT     : M0_HPROT;
    S_HMASTLOCK = own_q ? M1_HMASTLOCK : M0_HMASTLOCK;
    S_HWDATA    = down_q ? M1_HWDATA   : M0_HWDATA;
    M0_HRDATA   = S_HRDATA;
    M1_HRDATA   = S_HRDATA;
    M0_HREADY   = own_q  ? ~req0 : S_HREADYOUT;
    M1_HREADY   = own_q  ? S_HREADYOUT : ~req1;
    M0_HRESP    = dv_q && !down_q && S_HRESP;
    M1_HRESP    = dv_q &&  down_q && S_HRESP;
  end

`ifdef BFM_AHB_ARB2_STATS_EN
  logic [15:0] m0_wait_q, m0_wait_d;
  logic [15:0] m1_wait_q, m1_wait_d;
  logic [15:0] sw_q, sw_d;

  // Statistics next state: wait counters saturate, switch counter wraps.
  always_comb begin
    m0_wait_d = m0_wait_q;
    m1_wait_d = m1_wait_q;
    sw_d      = sw_q;
    if (req0 && own_q  && m0_wait_q != 16'hFFFF) m0_wait_d = m0_wait_q + 16'd1;
    if (req1 && !own_q && m1_wait_q != 16'hFFFF) m1_wait_d = m1_wait_q + 16'd1;
    if (own_d != own_q) sw_d = sw_q + 16'd1;
  end

  // Statistics registers, cleared with the arbiter state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m0_wait_q <= 16'd0;
      m1_wait_q <= 16'd0;
      sw_q      <= 16'd0;
    end else begin
      m0_wait_q <= m0_wait_d;
      m1_wait_q <= m1_wait_d;
      sw_q      <= sw_d;
    end
  end

  assign M0_WAITCNT = m0_wait_q;
  assign M1_WAITCNT = m1_wait_q;
  assign SWITCHCNT  = sw_q;
`endif

endmodule

// File: tb/tb_bfm_ahb_arb2.sv
// Scoreboard bench for bfm_ahb_arb2: directed master traffic pushes expected
// slave-side transfers; a negedge monitor pops and compares them as the slave
// accepts addresses and completes data phases. Stall/response checks are inline.
module tb_bfm_ahb_arb2;

  logic        HCLK, HRESET;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic        S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADYIN;
  logic [1:0]  S_HTRANS;
  logic [31:0] S_HADDR, S_HWDATA;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HREADYOUT, S_HRESP;
  logic [31:0] S_HRDATA;
`ifdef BFM_AHB_ARB2_STATS_EN
  logic [15:0] M0_WAITCNT, M1_WAITCNT, SWITCHCNT;
`endif

  bfm_ahb_arb2 #(.DEFAULT_OWNER(0), .TPD(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR),
    .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
    .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HREADYIN(S_HREADYIN), .S_HREADYOUT(S_HREADYOUT),
    .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP)
`ifdef BFM_AHB_ARB2_STATS_EN
    , .M0_WAITCNT(M0_WAITCNT), .M1_WAITCNT(M1_WAITCNT), .SWITCHCNT(SWITCHCNT)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic        lock;
    logic [31:0] wdata;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic l, input logic [31:0] d);
    exp_t e;
    e.addr = a; e.write = w; e.lock = l; e.wdata = d;
    expq.push_back(e);
  endtask

  // Monitor: data phase completes on the first ready cycle after acceptance,
  // then any newly accepted address is matched against the queue head.
  logic        pend;
  exp_t        cur;
  initial pend = 1'b0;
  always @(negedge HCLK) begin
    if (HRESET) begin
      pend = 1'b0;
    end else begin
      if (S_HREADYOUT && pend) begin
        if (cur.write) chk("s_hwdata", S_HWDATA, cur.wdata);
        pend = 1'b0;
      end
      if (S_HREADYOUT && S_HTRANS[1]) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer actual=%h required=none", S_HADDR);
        end else begin
          cur = expq.pop_front();
          chk("s_haddr", S_HADDR, cur.addr);
          chk("s_hwrite", 32'(S_HWRITE), 32'(cur.write));
          chk("s_hmastlock", 32'(S_HMASTLOCK), 32'(cur.lock));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HMASTLOCK = l;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HMASTLOCK = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    m0(2'b00, 32'h1111_0000, 1'b0, 1'b0);
    m1(2'b10, 32'h2222_0000, 1'b0, 1'b0);
    M0_HSIZE = 3'b010; M1_HSIZE = 3'b010;
    M0_HBURST = 3'b000; M1_HBURST = 3'b000;
    M0_HPROT = 4'b0011; M1_HPROT = 4'b0011;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    S_HREADYOUT = 1'b1; S_HRESP = 1'b1; S_HRDATA = 32'hDEAD_BEEF;
    #2;
    // In reset: owner M0 mirrored, requesting M1 stalled, no responses.
    chk("rst_haddr", S_HADDR, 32'h1111_0000);
    chk("rst_htrans", 32'(S_HTRANS), 32'd0);
    chk("rst_m0_hready", 32'(M0_HREADY), 32'd1);
    chk("rst_m1_hready", 32'(M1_HREADY), 32'd0);
    chk("rst_m0_hresp", 32'(M0_HRESP), 32'd0);
    chk("rst_m1_hresp", 32'(M1_HRESP), 32'd0);
    chk("rst_hsel", 32'(S_HSEL), 32'd1);
`ifdef BFM_AHB_ARB2_STATS_EN
    chk("rst_switchcnt", 32'(SWITCHCNT), 32'd0);
`endif
    m1(2'b00, 32'h2222_0000, 1'b0, 1'b0);
    S_HRESP = 1'b0;
    cyc(); HRESET = 1'b0;

    // M0 single write.
    cyc(); m0(2'b10, 32'h0100_0004, 1'b1, 1'b0); push(32'h0100_0004, 1'b1, 1'b0, 32'hA5A5_0001);
    #1 chk("t1_m1_hready_a", 32'(M1_HREADY), 32'd1);
    cyc(); m0(2'b00, 32'h0100_0004, 1'b0, 1'b0); M0_HWDATA = 32'hA5A5_0001;
    #1 chk("t1_m1_hready_d", 32'(M1_HREADY), 32'd1);
    chk("t1_wdata", S_HWDATA, 32'hA5A5_0001);

    // M1 requests while M0 idle: one dead cycle then forwarded.
    cyc(); M0_HWDATA = 32'h0; m1(2'b10, 32'h0300_0008, 1'b0, 1'b0); push(32'h0300_0008, 1'b0, 1'b0, 32'h0);
    #1 chk("t2_m1_dead", 32'(M1_HREADY), 32'd0);
    cyc();
    #1 chk("t2_m1_grant", 32'(M1_HREADY), 32'd1);
    chk("t2_haddr", S_HADDR, 32'h0300_0008);
`ifdef BFM_AHB_ARB2_STATS_EN
    chk("t2_switchcnt", 32'(SWITCHCNT), 32'd1);
`endif
    cyc(); m1(2'b00, 32'h0300_0008, 1'b0, 1'b0);

    // M0 locked 4-beat write; M1 requests on beat 1 and waits out the lock.
    cyc(); m0(2'b10, 32'h0400_0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(32'h0400_0000 + 32'(4*i), 1'b1, 1'b1, 32'hC0DE_0000 + 32'(i));
    #1 chk("t3_m0_dead", 32'(M0_HREADY), 32'd0);
    cyc();
    #1 chk("t3_m0_grant", 32'(M0_HREADY), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc(); m0(2'b11, 32'h0400_0000 + 32'(4*i), 1'b1, 1'b1); M0_HWDATA = 32'hC0DE_0000 + 32'(i-1);
      if (i == 1) begin
        m1(2'b10, 32'h0500_0000, 1'b1, 1'b0); push(32'h0500_0000, 1'b1, 1'b0, 32'h5555_AAAA);
      end
      #1 chk("t3_m1_stall_beat", 32'(M1_HREADY), 32'd0);
    end
    cyc(); m0(2'b00, 32'h0400_000C, 1'b0, 1'b1); M0_HWDATA = 32'hC0DE_0003;
    #1 chk("t3_m1_stall_lockidle", 32'(M1_HREADY), 32'd0);
    cyc(); m0(2'b00, 32'h0400_000C, 1'b0, 1'b0); M0_HWDATA = 32'h0;
    #1 chk("t3_m1_stall_unlock", 32'(M1_HREADY), 32'd0);
    chk("t3_own_hold", S_HADDR, 32'h0400_000C);
    cyc();
    #1 chk("t3_m1_grant", 32'(M1_HREADY), 32'd1);
`ifdef BFM_AHB_ARB2_STATS_EN
    chk("t3_m1_waitcnt", 32'(M1_WAITCNT), 32'd6);
`endif
    cyc(); m1(2'b00, 32'h0500_0000, 1'b0, 1'b0); M1_HWDATA = 32'h5555_AAAA;

    // ERROR response to M0 read.
    cyc(); M1_HWDATA = 32'h0; m0(2'b10, 32'h0200_0000, 1'b0, 1'b0); push(32'h0200_0000, 1'b0, 1'b0, 32'h0);
    #1 chk("t4_m0_dead", 32'(M0_HREADY), 32'd0);
    cyc();
    #1 chk("t4_m0_grant", 32'(M0_HREADY), 32'd1);
    cyc(); m0(2'b00, 32'h0200_0000, 1'b0, 1'b0); S_HREADYOUT = 1'b0; S_HRESP = 1'b1;
    #1 chk("t4_m0_hresp1", 32'(M0_HRESP), 32'd1);
    chk("t4_m1_hresp1", 32'(M1_HRESP), 32'd0);
    chk("t4_m0_hready1", 32'(M0_HREADY), 32'd0);
    cyc(); S_HREADYOUT = 1'b1;
    #1 chk("t4_m0_hresp2", 32'(M0_HRESP), 32'd1);
    chk("t4_m1_hresp2", 32'(M1_HRESP), 32'd0);
    cyc(); S_HRESP = 1'b0;
    #1 chk("t4_m0_hresp_end", 32'(M0_HRESP), 32'd0);
`ifdef BFM_AHB_ARB2_STATS_EN
    chk("t4_m0_waitcnt", 32'(M0_WAITCNT), 32'd2);
    chk("t4_switchcnt", 32'(SWITCHCNT), 32'd4);
`endif

    // Slave stall with M1 requesting: no switch until ready.
    cyc(); m0(2'b10, 32'h0600_0000, 1'b1, 1'b0); push(32'h0600_0000, 1'b1, 1'b0, 32'h6666_0000);
    #1 chk("t5_m0_direct", 32'(M0_HREADY), 32'd1);
    cyc(); m0(2'b00, 32'h0600_0000, 1'b0, 1'b0); M0_HWDATA = 32'h6666_0000; S_HREADYOUT = 1'b0;
    m1(2'b10, 32'h0700_0004, 1'b0, 1'b0); push(32'h0700_0004, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      if (i == 3) S_HREADYOUT = 1'b1;
      #1 chk("t5_m1_stall", 32'(M1_HREADY), 32'd0);
      chk("t5_own_hold", S_HADDR, 32'h0600_0000);
    end
    cyc(); M0_HWDATA = 32'h0;
    #1 chk("t5_m1_grant", 32'(M1_HREADY), 32'd1);
    chk("t5_haddr", S_HADDR, 32'h0700_0004);

    // Reset during the M1 data phase.
    cyc(); m1(2'b00, 32'h0700_0004, 1'b0, 1'b0); S_HRESP = 1'b1;
    #1 chk("t6_pre_rst_m1_hresp", 32'(M1_HRESP), 32'd1);
    HRESET = 1'b1;
    #1 chk("t6_rst_own", S_HADDR, 32'h0600_0000);
    chk("t6_rst_m1_hresp", 32'(M1_HRESP), 32'd0);
    chk("t6_rst_m0_hresp", 32'(M0_HRESP), 32'd0);
    chk("t6_rst_m1_hready", 32'(M1_HREADY), 32'd1);
`ifdef BFM_AHB_ARB2_STATS_EN
    chk("t6_rst_m0_waitcnt", 32'(M0_WAITCNT), 32'd0);
    chk("t6_rst_m1_waitcnt", 32'(M1_WAITCNT), 32'd0);
    chk("t6_rst_switchcnt", 32'(SWITCHCNT), 32'd0);
`endif
    S_HRESP = 1'b0;
    cyc(); HRESET = 1'b0;
    cyc(); cyc();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
